// File: rtl/id_issue_queue.sv
// id_issue_queue: DEPTH-entry decode-to-execute FIFO that replaces the ID/EXE
// pipeline register. Each micro-op carries NUM_SRC operands. Those operands
// capture writeback results at enqueue, and keep snooping them while the entry
// waits in the queue.
// Optional macro IDQ_WB_BYPASS_EN: when it is defined, the head operands also
// merge the current-cycle writeback combinationally. When it is undefined, the
// head operands come straight from storage.
module id_issue_queue #(
   parameter int UOP_W   = 128,
   parameter int DEPTH   = 4,
   parameter int NUM_SRC = 3,
   parameter int NUM_WB  = 2,
   parameter int IDX_W   = 6
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       flush_i,
   input  logic                       dec_valid_i,
   output logic                       dec_ready_o,
   input  logic [UOP_W-1:0]           dec_uop_i,
   input  logic [NUM_SRC*IDX_W-1:0]   dec_src_idx_i,
   input  logic [NUM_SRC-1:0]         dec_src_used_i,
   input  logic [NUM_SRC*32-1:0]      dec_src_data_i,
   input  logic [NUM_WB-1:0]          wb_en_i,
   input  logic [NUM_WB*IDX_W-1:0]    wb_idx_i,
   input  logic [NUM_WB*32-1:0]       wb_data_i,
   output logic                       exe_valid_o,
   input  logic                       exe_ready_i,
   output logic [UOP_W-1:0]           exe_uop_o,
   output logic [NUM_SRC*32-1:0]      exe_src_data_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [UOP_W-1:0]                r_uop  [DEPTH];
   logic [NUM_SRC-1:0][31:0]        r_data [DEPTH];
   logic [NUM_SRC-1:0][IDX_W-1:0]   r_idx  [DEPTH];
   logic [NUM_SRC-1:0]              r_used [DEPTH];
   logic [PTR_W-1:0]                r_wr_ptr;
   logic [PTR_W-1:0]                r_rd_ptr;
   logic [CNT_W-1:0]                r_count;

   logic                            w_enq;
   logic                            w_deq;
   logic [NUM_SRC-1:0][31:0]        w_enq_data;
   logic [NUM_SRC-1:0][31:0]        w_snp_data [DEPTH];
   logic [NUM_SRC-1:0]              w_snp_hit  [DEPTH];
   logic [DEPTH-1:0]                w_valid;

   // Writeback pick for one tag. Bit 32 flags a hit. On a hit, the data from
   // the highest-index matching port wins. Tag 0 (GPR x0) never matches.
   function automatic logic [32:0] f_wb_pick(
      input logic [IDX_W-1:0]        tag,
      input logic [31:0]             old,
      input logic [NUM_WB-1:0]       en,
      input logic [NUM_WB*IDX_W-1:0] idx,
      input logic [NUM_WB*32-1:0]    data
   );
      logic [32:0] v_res;
      v_res = {1'b0, old};
      for (int p = 0; p < NUM_WB; p++) begin
         if (en[p] && (idx[p*IDX_W +: IDX_W] == tag) && (tag != '0)) begin
            v_res = {1'b1, data[p*32 +: 32]};
         end
      end
      return v_res;
   endfunction

   assign dec_ready_o = !rst_i && !flush_i && (r_count < CNT_W'(DEPTH));
   assign exe_valid_o = (r_count != '0);
   assign w_enq       = dec_valid_i && dec_ready_o;
   assign w_deq       = exe_valid_o && exe_ready_i;
   assign exe_uop_o   = r_uop[r_rd_ptr];
   assign count_o     = r_count;

   // Operand capture for the incoming micro-op (regfile data, or forwarded writeback)
   always_comb begin
      logic [32:0] v_pick;
      w_enq_data = '0;
      for (int s = 0; s < NUM_SRC; s++) begin
         v_pick = f_wb_pick(dec_src_idx_i[s*IDX_W +: IDX_W], dec_src_data_i[s*32 +: 32],
                            wb_en_i, wb_idx_i, wb_data_i);
         w_enq_data[s] = dec_src_used_i[s] ? v_pick[31:0] : dec_src_data_i[s*32 +: 32];
      end
   end

   // Per-entry snoop: live entries compare their used operands against all writeback ports
   always_comb begin
      logic [PTR_W-1:0] v_off;
      logic [32:0]      v_pick;
      w_valid = '0;
      for (int e = 0; e < DEPTH; e++) begin
         v_off         = PTR_W'(e) - r_rd_ptr;
         w_valid[e]    = ({1'b0, v_off} < r_count);
         w_snp_hit[e]  = '0;
         w_snp_data[e] = '0;
         for (int s = 0; s < NUM_SRC; s++) begin
            v_pick = f_wb_pick(r_idx[e][s], r_data[e][s], wb_en_i, wb_idx_i, wb_data_i);
            w_snp_hit[e][s]  = w_valid[e] && r_used[e][s] && v_pick[32];
            w_snp_data[e][s] = v_pick[31:0];
         end
      end
   end

`ifdef IDQ_WB_BYPASS_EN
   // Head operands merged with this cycle's writeback so EXE sees it without a bubble
   always_comb begin
      logic [32:0] v_pick;
      exe_src_data_o = '0;
      for (int s = 0; s < NUM_SRC; s++) begin
         v_pick = f_wb_pick(r_idx[r_rd_ptr][s], r_data[r_rd_ptr][s], wb_en_i, wb_idx_i, wb_data_i);
         exe_src_data_o[s*32 +: 32] = r_used[r_rd_ptr][s] ? v_pick[31:0] : r_data[r_rd_ptr][s];
      end
   end
`else
   assign exe_src_data_o = r_data[r_rd_ptr];
`endif

   // Queue state: reset clears storage, flush only empties, otherwise snoop/enqueue/dequeue
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         for (int e = 0; e < DEPTH; e++) begin
            r_uop[e]  <= '0;
            r_data[e] <= '0;
            r_idx[e]  <= '0;
            r_used[e] <= '0;
         end
      end else if (flush_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         for (int e = 0; e < DEPTH; e++) begin
            for (int s = 0; s < NUM_SRC; s++) begin
               if (w_snp_hit[e][s]) begin
                  r_data[e][s] <= w_snp_data[e][s];
               end
            end
         end
         // The write slot is never live, so it cannot collide with a snoop update
         if (w_enq) begin
            r_uop[r_wr_ptr]  <= dec_uop_i;
            r_data[r_wr_ptr] <= w_enq_data;
            r_idx[r_wr_ptr]  <= dec_src_idx_i;
            r_used[r_wr_ptr] <= dec_src_used_i;
            r_wr_ptr         <= r_wr_ptr + 1'b1;
         end
         if (w_deq) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_enq, w_deq})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: tb/tb_id_issue_queue.sv
// Bench for id_issue_queue. A reference queue model predicts the head contents
// and the occupancy every cycle. A vector table drives the flow, fill/stall and
// wrap-around cases. Hand-written sequences cover forwarding, snoop, flush and
// reset taken mid-operation.
module tb_id_issue_queue;

   localparam int UOP_W   = 128;
   localparam int DEPTH   = 4;
   localparam int NUM_SRC = 3;
   localparam int NUM_WB  = 2;
   localparam int IDX_W   = 6;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          flush = 1'b0;
   logic          dec_valid = 1'b0;
   logic          exe_ready = 1'b0;
   logic [127:0]  dec_uop = '0;
   logic [17:0]   dec_idx = '0;
   logic [2:0]    dec_used = '0;
   logic [95:0]   dec_data = '0;
   logic [1:0]    wb_en = '0;
   logic [11:0]   wb_idx = '0;
   logic [63:0]   wb_data = '0;
   logic          dec_ready;
   logic          exe_valid;
   logic [127:0]  exe_uop;
   logic [95:0]   exe_data;
   logic [2:0]    count;

   int ncmp = 0;
   int nerr = 0;

   id_issue_queue #(.UOP_W(UOP_W), .DEPTH(DEPTH), .NUM_SRC(NUM_SRC), .NUM_WB(NUM_WB), .IDX_W(IDX_W)) dut (
      .clk_i(clk), .rst_i(rst), .flush_i(flush),
      .dec_valid_i(dec_valid), .dec_ready_o(dec_ready), .dec_uop_i(dec_uop),
      .dec_src_idx_i(dec_idx), .dec_src_used_i(dec_used), .dec_src_data_i(dec_data),
      .wb_en_i(wb_en), .wb_idx_i(wb_idx), .wb_data_i(wb_data),
      .exe_valid_o(exe_valid), .exe_ready_i(exe_ready), .exe_uop_o(exe_uop),
      .exe_src_data_o(exe_data), .count_o(count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      ncmp++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [127:0] uop;
      logic [17:0]  idx;
      logic [2:0]   used;
      logic [95:0]  data;
   } ent_t;

   ent_t q[$];
   ent_t m_h;
   ent_t m_e;
   logic m_deq;
   logic m_enq;

   function automatic logic [31:0] fwd(input logic [5:0] tag, input logic [31:0] old);
      logic [31:0] r = old;
      for (int p = 0; p < NUM_WB; p++) begin
         if (wb_en[p] && wb_idx[p*6 +: 6] == tag && tag != 6'd0) r = wb_data[p*32 +: 32];
      end
      return r;
   endfunction

   function automatic ent_t snoop(input ent_t e);
      ent_t r = e;
      for (int s = 0; s < NUM_SRC; s++) begin
         if (r.used[s]) r.data[s*32 +: 32] = fwd(r.idx[s*6 +: 6], r.data[s*32 +: 32]);
      end
      return r;
   endfunction

   // Scoreboard: compare the head against the model, then advance the model for the coming edge
   always @(negedge clk) begin
      chk("dec_ready", dec_ready, !rst && !flush && q.size() < DEPTH);
      chk("count", count, q.size());
      chk("exe_valid", exe_valid, q.size() != 0);
      if (q.size() != 0) begin
         m_h = q[0];
`ifdef IDQ_WB_BYPASS_EN
         m_h = snoop(m_h);
`endif
         chk("head_uop", exe_uop, m_h.uop);
         chk("head_data", exe_data, m_h.data);
      end
      if (rst || flush) begin
         q.delete();
      end else begin
         m_deq = (q.size() != 0) && exe_ready;
         m_enq = dec_valid && (q.size() < DEPTH);
         foreach (q[i]) q[i] = snoop(q[i]);
         if (m_deq) void'(q.pop_front());
         if (m_enq) begin
            m_e.uop  = dec_uop;
            m_e.idx  = dec_idx;
            m_e.used = dec_used;
            m_e.data = dec_data;
            q.push_back(snoop(m_e));
         end
      end
   end

   typedef struct {
      logic       dv;
      logic [7:0] uop;
      logic       rdy;
      logic [2:0] exp_cnt;
      logic       exp_vld;
   } vec_t;

   vec_t tbl[23];
   int   ntbl = 0;

   task automatic add(input logic dv, input logic [7:0] uop, input logic rdy,
                      input logic [2:0] cnt, input logic vld);
      tbl[ntbl].dv      = dv;
      tbl[ntbl].uop     = uop;
      tbl[ntbl].rdy     = rdy;
      tbl[ntbl].exp_cnt = cnt;
      tbl[ntbl].exp_vld = vld;
      ntbl++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Default operands: tags 1, 2, 33 with data 0x..11, 0x..22, 0x..33 tagged by the payload
   task automatic set_uop(input logic [7:0] uop);
      logic [31:0] w;
      w        = {24'd0, uop} << 8;
      dec_uop  = {120'd0, uop};
      dec_idx  = {6'd33, 6'd2, 6'd1};
      dec_used = 3'b111;
      dec_data = {w | 32'h33, w | 32'h22, w | 32'h11};
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // basic flow
      add(1, 8'h00, 1, 1, 1);
      add(0, 8'h00, 1, 0, 0);
      // fill / stall, 5th held until space appears
      add(1, 8'h20, 0, 1, 1);
      add(1, 8'h21, 0, 2, 1);
      add(1, 8'h22, 0, 3, 1);
      add(1, 8'h23, 0, 4, 1);
      add(1, 8'h24, 0, 4, 1);
      add(1, 8'h24, 1, 3, 1);
      add(1, 8'h24, 1, 3, 1);
      add(0, 8'h00, 1, 2, 1);
      add(0, 8'h00, 1, 1, 1);
      add(0, 8'h00, 1, 0, 0);
      // wrap-around
      for (int k = 0; k < 10; k++) add(1, 8'(k), 1, 1, 1);
      add(0, 8'h00, 1, 0, 0);

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_uop", exe_uop, 128'd0);
      chk("rst_data", exe_data, 96'd0);
      chk("rst_count", count, 3'd0);
      chk("rst_valid", exe_valid, 1'b0);

      for (int i = 0; i < ntbl; i++) begin
         dec_valid = tbl[i].dv;
         set_uop(tbl[i].uop);
         exe_ready = tbl[i].rdy;
         tick();
         chk($sformatf("vec%0d_count", i), count, tbl[i].exp_cnt);
         chk($sformatf("vec%0d_valid", i), exe_valid, tbl[i].exp_vld);
      end
      dec_valid = 1'b0;
      exe_ready = 1'b0;

      // enqueue forward: both ports hit tag 5, port 1 wins; operand 1 is x0, operand 2 tag 7
      dec_valid = 1'b1;
      dec_uop   = 128'hF0;
      dec_idx   = {6'd7, 6'd0, 6'd5};
      dec_used  = 3'b111;
      dec_data  = {32'h1, 32'h77, 32'h55};
      wb_en     = 2'b11;
      wb_idx    = {6'd5, 6'd5};
      wb_data   = {32'hBEEF, 32'hDEAD};
      tick();
      dec_valid = 1'b0;
      wb_en     = 2'b00;
      chk("fwd_port1_wins", exe_data[31:0], 32'hBEEF);
      tick();
      // snoop while stalled: port 0 writes tag 7, port 1 writes x0
      wb_en   = 2'b11;
      wb_idx  = {6'd0, 6'd7};
      wb_data = {32'hBAD, 32'h99};
      @(negedge clk);
`ifdef IDQ_WB_BYPASS_EN
      chk("snoop_same_cycle", exe_data[95:64], 32'h99);
`else
      chk("snoop_not_yet", exe_data[95:64], 32'h1);
`endif
      chk("x0_bypass_hold", exe_data[63:32], 32'h77);
      tick();
      wb_en = 2'b00;
      chk("snoop_next_cycle", exe_data[95:64], 32'h99);
      chk("x0_stored_hold", exe_data[63:32], 32'h77);
      chk("fwd_kept", exe_data[31:0], 32'hBEEF);
      exe_ready = 1'b1;
      tick();
      exe_ready = 1'b0;
      chk("snoop_drained", count, 3'd0);

      // flush with a uop offered in the same cycle
      for (int k = 0; k < 3; k++) begin
         dec_valid = 1'b1;
         set_uop(8'(8'h30 + k));
         tick();
      end
      chk("pre_flush_count", count, 3'd3);
      set_uop(8'h3F);
      flush = 1'b1;
      tick();
      flush     = 1'b0;
      dec_valid = 1'b0;
      chk("flush_count", count, 3'd0);
      chk("flush_valid", exe_valid, 1'b0);
      tick();
      chk("flush_noenq", count, 3'd0);

      // reset mid-operation drops entries and clears storage despite handshakes
      for (int k = 0; k < 2; k++) begin
         dec_valid = 1'b1;
         set_uop(8'(8'h40 + k));
         tick();
      end
      set_uop(8'h4F);
      exe_ready = 1'b1;
      rst = 1'b1;
      tick();
      rst       = 1'b0;
      dec_valid = 1'b0;
      exe_ready = 1'b0;
      chk("midrst_count", count, 3'd0);
      chk("midrst_valid", exe_valid, 1'b0);
      chk("midrst_uop", exe_uop, 128'd0);
      chk("midrst_data", exe_data, 96'd0);

      // post-reset: one more uop flows through normally
      dec_valid = 1'b1;
      exe_ready = 1'b1;
      set_uop(8'h55);
      tick();
      dec_valid = 1'b0;
      chk("post_rst_uop", exe_uop, 128'h55);
      tick();
      chk("post_rst_empty", count, 3'd0);

      repeat (2) tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
